instr_encoder_loader: RTL and testbench

//   Inverse of the core's control decoder: accepts instruction fields (kind, regs, funct, imm)

---
 rtl/instr_encoder_loader.sv | 134 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes RV64 instruction fields (R-type, ld, sd, beq) into 32-bit words
// and streams them into imem starting at word 0, one registered write per accepted word.
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   loaded_count,
  output logic              full,
  output logic              err_imm,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  localparam logic [1:0] K_RTYPE = 2'd0;
  localparam logic [1:0] K_LD    = 2'd1;
  localparam logic [1:0] K_SD    = 2'd2;

  state_t              state_q, state_d;
  logic                we_q, we_d, err_q, err_d, done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                xfer, imm_ok, accept, last_word;
  logic [31:0]         enc;

  assign xfer      = in_valid & in_ready;
  assign accept    = xfer & imm_ok;
  assign last_word = (cnt_q == (ADDR_W+1)'(DEPTH-1));

  always_comb begin
    imm_ok = 1'b1;
    enc    = '0;
    case (in_kind)
      K_RTYPE: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      K_LD: begin
        imm_ok = (in_imm[12] == in_imm[11]);
        enc    = {in_imm[11:0], in_rs1, 3'b011, in_rd, 7'b0000011};
      end
      K_SD: begin
        imm_ok = (in_imm[12] == in_imm[11]);
        enc    = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], 7'b0100011};
      end
      default: begin
        // branch offsets are halfword multiples; bit 0 is not encodable
        imm_ok = ~in_imm[0];
        enc    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                  in_imm[4:1], in_imm[11], 7'b1100011};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // start wins over finish so a restart never emits done
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (start)                   state_d = S_LOAD;
        else if (finish)             state_d = S_IDLE;
        else if (accept & last_word) state_d = S_FULL;
      end
      S_FULL: begin
        if (start)       state_d = S_LOAD;
        else if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_LOAD);
    full     = (state_q == S_FULL);
  end

  // A write accepted in the same cycle as start still lands at its old address.
  always_comb begin
    we_d    = accept;
    err_d   = xfer & ~imm_ok;
    done_d  = finish & ~start & (state_q != S_IDLE);
    addr_d  = accept ? cnt_q[ADDR_W-1:0] : addr_q;
    wdata_d = accept ? enc : wdata_q;
    cnt_d   = cnt_q;
    if (start)       cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      err_q   <= err_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign loaded_count = cnt_q;
  assign err_imm      = err_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4): expected imem writes are queued
// when a word is driven and checked by a monitor when imem_we fires.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset, start, finish, in_valid, in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [12:0]       in_imm;
  logic              imem_we, full, err_imm, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   loaded_count;

  int n_chk = 0, n_fail = 0;
  int err_seen = 0, done_seen = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  instr_encoder_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .loaded_count(loaded_count), .full(full), .err_imm(err_imm), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err_imm) err_seen++;
    if (done)    done_seen++;
    if (imem_we) begin
      chk("we_expected", 32'(exp_data.size() > 0), 32'd1);
      if (exp_data.size() > 0) begin
        chk("wr_addr", 32'(imem_addr), exp_addr.pop_front());
        chk("wr_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int a, input logic [31:0] d);
    exp_addr.push_back(32'(a));
    exp_data.push_back(d);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  task automatic set_fields(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [12:0] imm);
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Holds in_valid until the handshake completes or the cycle bound expires.
  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input int bound,
                      output logic ok);
    set_fields(k, rd, rs1, rs2, 3'd0, 7'd0, imm);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    set_fields(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", 32'(loaded_count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err_imm), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    chk("idle_not_ready", 32'(in_ready), 0);

    // add x3,x1,x2
    pulse_start();
    chk("load_ready", 32'(in_ready), 1);
    push(0, 32'h002081B3);
    send(2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 4, ok);
    chk("rtype_acc", 32'(ok), 1);
    tick();
    chk("count_1", 32'(loaded_count), 1);

    // restart: ld x5,8(x2); sd x5,-4(x2); beq x1,x2,-8
    pulse_start();
    chk("restart_count", 32'(loaded_count), 0);
    push(0, 32'h00813283);
    send(2'd1, 5'd5, 5'd2, 5'd0, 13'd8, 4, ok);
    push(1, 32'hFE513E23);
    send(2'd2, 5'd0, 5'd2, 5'd5, 13'h1FFC, 4, ok);
    tick();
    chk("count_2", 32'(loaded_count), 2);
    push(2, 32'hFE208CE3);
    send(2'd3, 5'd0, 5'd1, 5'd2, 13'h1FF8, 4, ok);
    tick();
    chk("count_3", 32'(loaded_count), 3);

    // rejected immediates: odd branch offset, then ld offset 2048
    send(2'd3, 5'd0, 5'd1, 5'd2, 13'd3, 4, ok);
    chk("beq_bad_acc", 32'(ok), 1);
    tick();
    chk("beq_err", 32'(err_seen), 1);
    chk("beq_count", 32'(loaded_count), 3);
    send(2'd1, 5'd5, 5'd2, 5'd0, 13'h0800, 4, ok);
    tick();
    chk("ld_err", 32'(err_seen), 2);
    chk("ld_count", 32'(loaded_count), 3);

    pulse_finish();
    tick();
    chk("done_1", 32'(done_seen), 1);
    chk("idle_after_finish", 32'(in_ready), 0);

    // fill all DEPTH words; the extra word must be held off
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) push(i, 32'h00208033 | (32'(i) << 7));
      send(2'd0, 5'(i), 5'd1, 5'd2, 13'd0, 4, ok);
      chk("stream_acc", 32'(ok), 32'(i < DEPTH));
    end
    chk("full_flag", 32'(full), 1);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_count", 32'(loaded_count), DEPTH);
    pulse_finish();
    tick();
    chk("done_2", 32'(done_seen), 2);

    // transfer and finish together
    pulse_start();
    push(0, 32'h00208033 | (32'd7 << 7));
    set_fields(2'd0, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    in_valid = 1'b1; finish = 1'b1;
    tick();
    in_valid = 1'b0; finish = 1'b0;
    chk("vf_idle", 32'(in_ready), 0);
    chk("vf_count", 32'(loaded_count), 1);
    repeat (3) tick();
    chk("vf_done_once", 32'(done_seen), 3);

    // reset while a word is being offered in LOAD
    pulse_start();
    set_fields(2'd0, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    in_valid = 1'b1;
    #3 reset = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_we", 32'(imem_we), 0);
    chk("mr_ready", 32'(in_ready), 0);
    chk("mr_addr", 32'(imem_addr), 0);
    chk("mr_wdata", imem_wdata, 0);
    chk("mr_count", 32'(loaded_count), 0);
    chk("mr_full", 32'(full), 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("mr_idle", 32'(in_ready), 0);
    chk("queue_drained", 32'(exp_data.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
